// File: rtl/spi_master_param.sv
// spi_master_param: SPI master with a command FIFO, programmable mode, clock
// divider, chip-select setup time and inter-frame gap.
// Optional receive path enabled by defining SPI_MASTER_PARAM_RX_EN.
// All SPI pins and status outputs come straight from flip-flops. Each output
// register is loaded from the next-state values, so it lines up cycle-exactly
// with the FSM state register.
module spi_master_param #(
  parameter int DATA_W     = 16,
  parameter int SS_W       = 16,
  parameter int CLK_DIV    = 20,
  parameter int SETUP_CYC  = 20,
  parameter int END_CYC    = 15,
  parameter int FIFO_DEPTH = 4,
  parameter bit CPOL       = 1'b0,
  parameter bit CPHA       = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [DATA_W-1:0] cmd_data,
  input  logic [SS_W-1:0]   cmd_ss,
  input  logic              hold,
  output logic              spi_sclk,
  output logic              spi_mosi,
  input  logic              spi_miso,
  output logic [SS_W-1:0]   spi_ss_n,
  output logic              busy,
  output logic              rx_valid,
  output logic [DATA_W-1:0] rx_data
);

  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_FW = PTR_W + 1;
  localparam int MAX_AB = (SETUP_CYC > END_CYC) ? SETUP_CYC : END_CYC;
  localparam int MAXC   = (MAX_AB > CLK_DIV) ? MAX_AB : CLK_DIV;
  localparam int CYC_W  = (MAXC > 1) ? $clog2(MAXC) : 1;
  localparam int BIT_W  = $clog2(DATA_W);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_SETUP = 3'd2,
    ST_SHIFT = 3'd3,
    ST_END   = 3'd4
  } state_t;

  state_t             state, state_nx;
  logic [CYC_W-1:0]   cyc, cyc_nx;
  logic               half, half_nx;
  logic [BIT_W-1:0]   bit_cnt, bit_nx;

  logic [DATA_W-1:0]  mem_data [FIFO_DEPTH];
  logic [SS_W-1:0]    mem_ss   [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr, rd_ptr;
  logic [CNT_FW-1:0]  count, count_nx;
  logic               push, pop;
  logic [DATA_W-1:0]  rd_data;
  logic [SS_W-1:0]    rd_ss;

  logic [DATA_W-1:0]  sreg, sreg_nx;
  logic [SS_W-1:0]    ss_mask, ss_mask_nx;
  logic               sclk_nx, mosi_nx, busy_nx, ready_nx;
  logic [SS_W-1:0]    ss_n_nx;
  logic               lead, trail;

  assign push     = cmd_valid && cmd_ready;
  assign pop      = (state == ST_LOAD);
  assign rd_data  = mem_data[rd_ptr];
  assign rd_ss    = mem_ss[rd_ptr];
  assign count_nx = count + CNT_FW'(push) - CNT_FW'(pop);

  // Command FIFO storage and pointers; a full FIFO never accepts.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_data[i] <= '0;
        mem_ss[i]   <= '0;
      end
    end else begin
      if (push) begin
        mem_data[wr_ptr] <= cmd_data;
        mem_ss[wr_ptr]   <= cmd_ss;
        wr_ptr           <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      count <= count_nx;
    end
  end

  // FSM state register with its phase counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      cyc     <= '0;
      half    <= 1'b0;
      bit_cnt <= '0;
    end else begin
      state   <= state_nx;
      cyc     <= cyc_nx;
      half    <= half_nx;
      bit_cnt <= bit_nx;
    end
  end

  // Next-state logic: SETUP/END are timed by cyc, SHIFT runs half-periods of CLK_DIV.
  always_comb begin
    state_nx = state;
    cyc_nx   = cyc;
    half_nx  = half;
    bit_nx   = bit_cnt;
    case (state)
      ST_IDLE: begin
        if ((count != '0) && !hold) state_nx = ST_LOAD;
        else                        state_nx = ST_IDLE;
      end
      ST_LOAD: begin
        state_nx = ST_SETUP;
        cyc_nx   = '0;
      end
      ST_SETUP: begin
        if (cyc == CYC_W'(SETUP_CYC - 1)) begin
          state_nx = ST_SHIFT;
          cyc_nx   = '0;
          half_nx  = 1'b0;
          bit_nx   = '0;
        end else begin
          cyc_nx = cyc + CYC_W'(1);
        end
      end
      ST_SHIFT: begin
        if (cyc == CYC_W'(CLK_DIV - 1)) begin
          cyc_nx = '0;
          if (half) begin
            half_nx = 1'b0;
            if (bit_cnt == BIT_W'(DATA_W - 1)) state_nx = ST_END;
            else                               bit_nx   = bit_cnt + BIT_W'(1);
          end else begin
            half_nx = 1'b1;
          end
        end else begin
          cyc_nx = cyc + CYC_W'(1);
        end
      end
      ST_END: begin
        if (cyc == CYC_W'(END_CYC - 1)) begin
          state_nx = ST_IDLE;
          cyc_nx   = '0;
        end else begin
          cyc_nx = cyc + CYC_W'(1);
        end
      end
      default: begin
        state_nx = ST_IDLE;
        cyc_nx   = '0;
        half_nx  = 1'b0;
        bit_nx   = '0;
      end
    endcase
  end

  // Leading edge: entering the active half of an SCLK period; trailing: leaving it.
  assign lead  = (state_nx == ST_SHIFT) && !half_nx && ((state != ST_SHIFT) || half);
  assign trail = (state == ST_SHIFT) && (state_nx == ST_SHIFT) && !half && half_nx;

  // Output logic: next values for the pin, shift and status registers.
  always_comb begin
    if ((state_nx == ST_SHIFT) && !half_nx) sclk_nx = ~CPOL;
    else                                    sclk_nx = CPOL;

    if (pop) ss_mask_nx = rd_ss;
    else     ss_mask_nx = ss_mask;

    if ((state_nx == ST_SETUP) || (state_nx == ST_SHIFT)) ss_n_nx = ~ss_mask_nx;
    else                                                  ss_n_nx = '1;

    sreg_nx = sreg;
    mosi_nx = spi_mosi;
    if (pop) begin
      sreg_nx = rd_data;
      if (CPHA == 1'b0) mosi_nx = rd_data[DATA_W-1];
      else              mosi_nx = 1'b0;
    end else if ((CPHA == 1'b0) && trail) begin
      mosi_nx = sreg[DATA_W-2];
      sreg_nx = {sreg[DATA_W-2:0], 1'b0};
    end else if ((CPHA == 1'b1) && lead) begin
      mosi_nx = sreg[DATA_W-1];
      sreg_nx = {sreg[DATA_W-2:0], 1'b0};
    end else begin
      sreg_nx = sreg;
    end

    busy_nx  = (state_nx != ST_IDLE) || (count_nx != '0);
    ready_nx = (count_nx != CNT_FW'(FIFO_DEPTH));
  end

  // Registered SPI pins and status outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      spi_sclk  <= CPOL;
      spi_mosi  <= 1'b0;
      spi_ss_n  <= '1;
      busy      <= 1'b0;
      cmd_ready <= 1'b0;
      sreg      <= '0;
      ss_mask   <= '0;
    end else begin
      spi_sclk  <= sclk_nx;
      spi_mosi  <= mosi_nx;
      spi_ss_n  <= ss_n_nx;
      busy      <= busy_nx;
      cmd_ready <= ready_nx;
      sreg      <= sreg_nx;
      ss_mask   <= ss_mask_nx;
    end
  end

`ifdef SPI_MASTER_PARAM_RX_EN
  logic [DATA_W-1:0] rx_sreg, rx_sreg_nx;
  logic              rx_sample, rx_done;

  assign rx_sample = (CPHA == 1'b0) ? lead : trail;
  assign rx_done   = (state == ST_SHIFT) && (state_nx == ST_END);

  // Receive shift-in on the sampling edge.
  always_comb begin
    if (rx_sample) rx_sreg_nx = {rx_sreg[DATA_W-2:0], spi_miso};
    else           rx_sreg_nx = rx_sreg;
  end

  // Receive registers: rx_data updates and rx_valid pulses as SHIFT ends.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_sreg  <= '0;
      rx_valid <= 1'b0;
      rx_data  <= '0;
    end else begin
      rx_sreg  <= rx_sreg_nx;
      rx_valid <= rx_done;
      if (rx_done) rx_data <= rx_sreg;
      else         rx_data <= rx_data;
    end
  end
`else
  logic unused_miso;
  assign unused_miso = spi_miso;
  assign rx_valid    = 1'b0;
  assign rx_data     = '0;
`endif

endmodule

// File: tb/tb_spi_master_param.sv
// Directed bench for spi_master_param: a default-parameter instance (u0) and
// a mode-3, 8-bit instance (u1); both have miso looped back from mosi.
module tb_spi_master_param;
`ifdef SPI_MASTER_PARAM_RX_EN
  localparam bit RX = 1'b1;
`else
  localparam bit RX = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic        v0 = 1'b0, h0 = 1'b0;
  logic [15:0] d0 = 16'h0000, s0 = 16'h0000;
  logic        rdy0, sclk0, mosi0, busy0, rxv0;
  logic [15:0] ss0, rxd0;

  logic        v1 = 1'b0, h1 = 1'b0;
  logic [7:0]  d1 = 8'h00;
  logic [3:0]  s1 = 4'h0;
  logic        rdy1, sclk1, mosi1, busy1, rxv1;
  logic [3:0]  ss1;
  logic [7:0]  rxd1;

  spi_master_param u0 (
    .clk(clk), .rst(rst), .cmd_valid(v0), .cmd_ready(rdy0), .cmd_data(d0), .cmd_ss(s0),
    .hold(h0), .spi_sclk(sclk0), .spi_mosi(mosi0), .spi_miso(mosi0), .spi_ss_n(ss0),
    .busy(busy0), .rx_valid(rxv0), .rx_data(rxd0)
  );

  spi_master_param #(.DATA_W(8), .SS_W(4), .CLK_DIV(2), .SETUP_CYC(3), .END_CYC(2),
                     .FIFO_DEPTH(2), .CPOL(1'b1), .CPHA(1'b1)) u1 (
    .clk(clk), .rst(rst), .cmd_valid(v1), .cmd_ready(rdy1), .cmd_data(d1), .cmd_ss(s1),
    .hold(h1), .spi_sclk(sclk1), .spi_mosi(mosi1), .spi_miso(mosi1), .spi_ss_n(ss1),
    .busy(busy1), .rx_valid(rxv1), .rx_data(rxd1)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // observation results for u0
  int          o_frames, o_gap_min, o_rises, o_rxp, o_busy_cyc, o_first_low, o_first_rise;
  int          o_low_len [8];
  logic [15:0] o_ss [8];
  logic [15:0] o_bits, o_rxd;

  task automatic push0(input logic [15:0] d, input logic [15:0] s);
    @(negedge clk);
    v0 = 1'b1; d0 = d; s0 = s;
    @(posedge clk);
    #1 v0 = 1'b0;
  endtask

  // Watch u0 for ncyc falling edges; optionally raise hold at a given SCLK rise.
  task automatic observe(input int ncyc, input int hold_rise);
    logic low, prev_low, prev_sclk;
    int high_run;
    o_frames = 0; o_gap_min = 1000000; o_rises = 0; o_rxp = 0; o_busy_cyc = 0;
    o_first_low = -1; o_first_rise = -1; o_bits = 16'h0000; o_rxd = 16'h0000;
    for (int k = 0; k < 8; k++) begin o_low_len[k] = 0; o_ss[k] = 16'h0000; end
    prev_low = 1'b0; prev_sclk = 1'b0; high_run = 0;
    for (int i = 0; i < ncyc; i++) begin
      @(negedge clk);
      low = (ss0 != 16'hFFFF);
      if (low && !prev_low) begin
        if (o_frames > 0 && high_run < o_gap_min) o_gap_min = high_run;
        if (o_frames == 0) o_first_low = i;
        if (o_frames < 8) o_ss[o_frames] = ss0;
        o_frames++;
      end
      if (low) begin
        high_run = 0;
        if (o_frames >= 1 && o_frames <= 8) o_low_len[o_frames-1]++;
      end else begin
        high_run++;
      end
      if (sclk0 && !prev_sclk) begin
        if (o_rises == 0) o_first_rise = i;
        o_rises++;
        o_bits = {o_bits[14:0], mosi0};
        if (hold_rise > 0 && o_rises == hold_rise) h0 = 1'b1;
      end
      if (rxv0) begin o_rxp++; o_rxd = rxd0; end
      if (busy0) o_busy_cyc++;
      prev_low = low; prev_sclk = sclk0;
    end
  endtask

  task automatic test_reset;
    #2 rst = 1'b1;
    #1;
    n_checks++; if (sclk0 !== 1'b0)     begin n_fail++; $display("FAIL rst_sclk0: got %b expected 0", sclk0); end
    n_checks++; if (sclk1 !== 1'b1)     begin n_fail++; $display("FAIL rst_sclk1: got %b expected 1", sclk1); end
    n_checks++; if (mosi0 !== 1'b0)     begin n_fail++; $display("FAIL rst_mosi: got %b expected 0", mosi0); end
    n_checks++; if (ss0 !== 16'hFFFF)   begin n_fail++; $display("FAIL rst_ss_n: got %h expected ffff", ss0); end
    n_checks++; if (busy0 !== 1'b0)     begin n_fail++; $display("FAIL rst_busy: got %b expected 0", busy0); end
    n_checks++; if (rdy0 !== 1'b0)      begin n_fail++; $display("FAIL rst_ready: got %b expected 0", rdy0); end
    n_checks++; if (rxv0 !== 1'b0)      begin n_fail++; $display("FAIL rst_rx_valid: got %b expected 0", rxv0); end
    n_checks++; if (rxd0 !== 16'h0000)  begin n_fail++; $display("FAIL rst_rx_data: got %h expected 0", rxd0); end
    repeat (3) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    @(negedge clk);
    n_checks++; if (rdy0 !== 1'b1)      begin n_fail++; $display("FAIL rel_ready0: got %b expected 1", rdy0); end
    n_checks++; if (rdy1 !== 1'b1)      begin n_fail++; $display("FAIL rel_ready1: got %b expected 1", rdy1); end
  endtask

  task automatic test_basic;
    push0(16'hA5C3, 16'h0004);
    observe(700, 0);
    n_checks++; if (o_first_low != 2)      begin n_fail++; $display("FAIL basic_ss_latency: got %0d expected 2", o_first_low); end
    n_checks++; if (o_frames != 1)         begin n_fail++; $display("FAIL basic_frames: got %0d expected 1", o_frames); end
    n_checks++; if (o_ss[0] !== 16'hFFFB)  begin n_fail++; $display("FAIL basic_ss_val: got %h expected fffb", o_ss[0]); end
    n_checks++; if (o_low_len[0] != 660)   begin n_fail++; $display("FAIL basic_ss_len: got %0d expected 660", o_low_len[0]); end
    n_checks++; if (o_rises != 16)         begin n_fail++; $display("FAIL basic_rises: got %0d expected 16", o_rises); end
    n_checks++; if (o_first_rise != 22)    begin n_fail++; $display("FAIL basic_first_edge: got %0d expected 22", o_first_rise); end
    n_checks++; if (o_bits !== 16'hA5C3)   begin n_fail++; $display("FAIL basic_mosi: got %h expected a5c3", o_bits); end
    n_checks++; if (o_busy_cyc != 677)     begin n_fail++; $display("FAIL basic_busy: got %0d expected 677", o_busy_cyc); end
    n_checks++; if (o_rxp != (RX ? 1 : 0)) begin n_fail++; $display("FAIL basic_rx_pulse: got %0d expected %0d", o_rxp, RX ? 1 : 0); end
    n_checks++; if (o_rxd !== (RX ? 16'hA5C3 : 16'h0000)) begin n_fail++; $display("FAIL basic_rx_data: got %h", o_rxd); end
    n_checks++; if (rxd0 !== (RX ? 16'hA5C3 : 16'h0000))  begin n_fail++; $display("FAIL basic_rx_hold: got %h", rxd0); end
  endtask

  task automatic test_mode3;
    int low_len, falls, rises, rxp, viol;
    logic [7:0] bits, rxd;
    logic [3:0] ssv;
    logic ps;
    low_len = 0; falls = 0; rises = 0; rxp = 0; viol = 0; bits = 8'h00; rxd = 8'h00; ssv = 4'hF; ps = 1'b1;
    @(negedge clk);
    v1 = 1'b1; d1 = 8'h3C; s1 = 4'b0010;
    @(posedge clk);
    #1 v1 = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (ss1 != 4'hF) begin low_len++; ssv = ss1; end
      else if (sclk1 !== 1'b1) viol++;
      if (!sclk1 && ps) falls++;
      if (sclk1 && !ps) begin rises++; bits = {bits[6:0], mosi1}; end
      if (rxv1) begin rxp++; rxd = rxd1; end
      ps = sclk1;
    end
    n_checks++; if (low_len != 35)       begin n_fail++; $display("FAIL m3_ss_len: got %0d expected 35", low_len); end
    n_checks++; if (ssv !== 4'b1101)     begin n_fail++; $display("FAIL m3_ss_val: got %b expected 1101", ssv); end
    n_checks++; if (falls != 8)          begin n_fail++; $display("FAIL m3_lead_edges: got %0d expected 8", falls); end
    n_checks++; if (rises != 8)          begin n_fail++; $display("FAIL m3_trail_edges: got %0d expected 8", rises); end
    n_checks++; if (bits !== 8'h3C)      begin n_fail++; $display("FAIL m3_mosi: got %h expected 3c", bits); end
    n_checks++; if (viol != 0)           begin n_fail++; $display("FAIL m3_sclk_idle: got %0d bad cycles expected 0", viol); end
    n_checks++; if (rxp != (RX ? 1 : 0)) begin n_fail++; $display("FAIL m3_rx_pulse: got %0d expected %0d", rxp, RX ? 1 : 0); end
    n_checks++; if (rxd !== (RX ? 8'h3C : 8'h00)) begin n_fail++; $display("FAIL m3_rx_data: got %h", rxd); end
  endtask

  task automatic test_fifo_hold;
    logic [15:0] sel;
    @(negedge clk) h0 = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      n_checks++; if (rdy0 !== (k < 4)) begin n_fail++; $display("FAIL fifo_ready_%0d: got %b expected %b", k, rdy0, (k < 4)); end
      v0 = 1'b1; d0 = 16'h1111 * 16'(k + 1); s0 = 16'h0001 << k;
      @(posedge clk);
      #1;
    end
    v0 = 1'b0;
    observe(50, 0);
    n_checks++; if (o_frames != 0)     begin n_fail++; $display("FAIL hold_ss: got %0d frames expected 0", o_frames); end
    n_checks++; if (o_busy_cyc != 50)  begin n_fail++; $display("FAIL hold_busy: got %0d expected 50", o_busy_cyc); end
    h0 = 1'b0;
    observe(2900, 0);
    n_checks++; if (o_frames != 4)     begin n_fail++; $display("FAIL fifo_frames: got %0d expected 4", o_frames); end
    n_checks++; if (o_gap_min < 17)    begin n_fail++; $display("FAIL fifo_gap: got %0d expected >=17", o_gap_min); end
    for (int k = 0; k < 4; k++) begin
      sel = 16'h0001 << k;
      n_checks++; if (o_ss[k] !== ~sel)    begin n_fail++; $display("FAIL fifo_order_%0d: got %h expected %h", k, o_ss[k], ~sel); end
      n_checks++; if (o_low_len[k] != 660) begin n_fail++; $display("FAIL fifo_len_%0d: got %0d expected 660", k, o_low_len[k]); end
    end
    n_checks++; if (busy0 !== 1'b0)    begin n_fail++; $display("FAIL fifo_idle_busy: got %b expected 0", busy0); end
  endtask

  task automatic test_hold_midframe;
    push0(16'h0F0F, 16'h8000);
    observe(700, 3);
    n_checks++; if (o_frames != 1)        begin n_fail++; $display("FAIL hmid_frames: got %0d expected 1", o_frames); end
    n_checks++; if (o_low_len[0] != 660)  begin n_fail++; $display("FAIL hmid_len: got %0d expected 660", o_low_len[0]); end
    n_checks++; if (o_rises != 16)        begin n_fail++; $display("FAIL hmid_rises: got %0d expected 16", o_rises); end
    n_checks++; if (o_bits !== 16'h0F0F)  begin n_fail++; $display("FAIL hmid_mosi: got %h expected 0f0f", o_bits); end
    n_checks++; if (o_busy_cyc != 677)    begin n_fail++; $display("FAIL hmid_busy: got %0d expected 677", o_busy_cyc); end
    h0 = 1'b0;
  endtask

  task automatic test_zero_ss;
    push0(16'h8001, 16'h0000);
    observe(700, 0);
    n_checks++; if (o_frames != 0)        begin n_fail++; $display("FAIL zss_ss: got %0d frames expected 0", o_frames); end
    n_checks++; if (o_rises != 16)        begin n_fail++; $display("FAIL zss_rises: got %0d expected 16", o_rises); end
    n_checks++; if (o_bits !== 16'h8001)  begin n_fail++; $display("FAIL zss_mosi: got %h expected 8001", o_bits); end
    n_checks++; if (o_busy_cyc != 677)    begin n_fail++; $display("FAIL zss_busy: got %0d expected 677", o_busy_cyc); end
    n_checks++; if (o_rxd !== (RX ? 16'h8001 : 16'h0000)) begin n_fail++; $display("FAIL zss_rx_data: got %h", o_rxd); end
  endtask

  task automatic test_reset_midframe;
    int rises;
    logic ps;
    rises = 0; ps = 1'b0;
    push0(16'hFFFF, 16'h0001);
    push0(16'h1234, 16'h0002);
    for (int i = 0; i < 400 && rises < 5; i++) begin
      @(negedge clk);
      if (sclk0 && !ps) rises++;
      ps = sclk0;
    end
    n_checks++; if (rises != 5) begin n_fail++; $display("FAIL mrst_reach_edge5: got %0d edges expected 5", rises); end
    #2 rst = 1'b1;
    #1;
    n_checks++; if (sclk0 !== 1'b0)    begin n_fail++; $display("FAIL mrst_sclk: got %b expected 0", sclk0); end
    n_checks++; if (ss0 !== 16'hFFFF)  begin n_fail++; $display("FAIL mrst_ss_n: got %h expected ffff", ss0); end
    n_checks++; if (mosi0 !== 1'b0)    begin n_fail++; $display("FAIL mrst_mosi: got %b expected 0", mosi0); end
    n_checks++; if (busy0 !== 1'b0)    begin n_fail++; $display("FAIL mrst_busy: got %b expected 0", busy0); end
    n_checks++; if (rdy0 !== 1'b0)     begin n_fail++; $display("FAIL mrst_ready: got %b expected 0", rdy0); end
    n_checks++; if (rxv0 !== 1'b0)     begin n_fail++; $display("FAIL mrst_rx_valid: got %b expected 0", rxv0); end
    @(negedge clk) rst = 1'b0;
    @(negedge clk);
    n_checks++; if (rdy0 !== 1'b1)     begin n_fail++; $display("FAIL mrst_rel_ready: got %b expected 1", rdy0); end
    n_checks++; if (busy0 !== 1'b0)    begin n_fail++; $display("FAIL mrst_rel_busy: got %b expected 0", busy0); end
    observe(800, 0);
    n_checks++; if (o_frames != 0)     begin n_fail++; $display("FAIL mrst_discard: got %0d frames expected 0", o_frames); end
    n_checks++; if (o_busy_cyc != 0)   begin n_fail++; $display("FAIL mrst_discard_busy: got %0d expected 0", o_busy_cyc); end
    n_checks++; if (o_rxp != 0)        begin n_fail++; $display("FAIL mrst_rx_pulse: got %0d expected 0", o_rxp); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_mode3();
    test_fifo_hold();
    test_hold_midframe();
    test_zero_ss();
    test_reset_midframe();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/spi_master_param.md
SPI_MASTER_PARAM -- requirements
Module: spi_master_param

Interface
REQ-001 SHALL have parameter DATA_W, default 16, bits per SPI frame (>=2).
REQ-002 SHALL have parameter SS_W, default 16, number of chip-select lines.
REQ-003 SHALL have parameter CLK_DIV, default 20, SCLK half-period in clk cycles (>=1).
REQ-004 SHALL have parameter SETUP_CYC, default 20, clk cycles from ss_n assertion to first SCLK edge (>=1).
REQ-005 SHALL have parameter END_CYC, default 15, minimum clk cycles ss_n held all-high between frames (>=1).
REQ-006 SHALL have parameter FIFO_DEPTH, default 4, command FIFO entries (power of 2, >=2).
REQ-007 SHALL have parameters CPOL and CPHA, default 0 and 0, SPI mode select.
REQ-008 SHALL have clk  input  1  sole clock; all logic on its rising edge.
REQ-009 SHALL have rst  input  1  asynchronous, active-high reset.
REQ-010 SHALL have cmd_valid  input  1, cmd_ready  output  1, cmd_data  input  DATA_W  (frame, MSB first), cmd_ss  input  SS_W  (active-high select mask).
REQ-011 SHALL have hold  input  1  external bus-busy; blocks start of a new frame.
REQ-012 SHALL have spi_sclk  output  1, spi_mosi  output  1, spi_miso  input  1, spi_ss_n  output  SS_W  (active-low).
REQ-013 SHALL have busy  output  1, rx_valid  output  1, rx_data  output  DATA_W.

Function
REQ-014 Command accepted on a rising edge with cmd_valid && cmd_ready; cmd_ready = FIFO not full; no accept when full, even if a pop occurs that cycle.
REQ-015 FSM states: IDLE, LOAD, SETUP, SHIFT, END.
REQ-016 IDLE -> LOAD when FIFO non-empty && !hold; otherwise remain in IDLE.
REQ-017 LOAD pops exactly one FIFO entry in one cycle, loads the shift register and SS mask, and goes to SETUP.
REQ-018 With an idle block, empty FIFO and hold low, spi_ss_n SHALL go low 2 clk edges after the accept edge.
REQ-019 spi_ss_n = ~cmd_ss during SETUP and SHIFT, all-ones otherwise; spi_ss_n low for exactly SETUP_CYC + 2*CLK_DIV*DATA_W cycles per frame.
REQ-020 SHIFT produces exactly DATA_W SCLK periods of 2*CLK_DIV clk each; spi_sclk = CPOL whenever not in SHIFT.
REQ-021 CPHA=0: MSB on spi_mosi from SETUP entry; spi_miso sampled on leading edge; mosi advances on trailing edge.
REQ-022 CPHA=1: mosi advances on leading edge; spi_miso sampled on trailing edge.
REQ-023 hold is ignored once a frame has left IDLE; the frame always completes.
REQ-024 END lasts END_CYC cycles, then IDLE; back-to-back frames therefore have ss_n high >= END_CYC+2 cycles.
REQ-025 busy = (state != IDLE) || FIFO non-empty.
REQ-026 spi_sclk, spi_mosi and spi_ss_n SHALL be driven directly from flip-flops (glitch-free).
REQ-027 cmd_ss of all zeros SHALL still run a full frame with no ss_n line asserted.

Reset
REQ-028 rst asserted SHALL immediately force state IDLE, FIFO empty, spi_sclk=CPOL, spi_mosi=0, spi_ss_n all-ones, busy=0, rx_valid=0, rx_data=0, cmd_ready=0.
REQ-029 cmd_ready SHALL be 1 from the first edge after rst deasserts.
REQ-030 Reset mid-frame SHALL abort the frame with no rx_valid pulse; the aborted command and all queued commands are discarded.

Configuration
REQ-031 Macro SPI_MASTER_PARAM_RX_EN defined: received bits shift into an internal register; on the SHIFT->END transition rx_data is updated and rx_valid pulses high for exactly one cycle.
REQ-032 Macro SPI_MASTER_PARAM_RX_EN undefined: no receive register is built, spi_miso is unused, rx_valid is constant 0 and rx_data is constant 0.

Verification
REQ-033 Defaults, CPOL=0, CPHA=0: push cmd_data=16'hA5C3, cmd_ss=16'h0004 -> spi_ss_n=16'hFFFB for 20+640 cycles; 16 rising SCLK edges; mosi bits 1010010111000011.
REQ-034 CPOL=1, CPHA=1, DATA_W=8, CLK_DIV=2: miso loopback from mosi with 8'h3C, RX_EN defined -> sclk idle high; rx_valid single pulse; rx_data=8'h3C.
REQ-035 FIFO_DEPTH=4 with hold=1: push 5 commands -> 4 accepted, cmd_ready=0 on the 5th; release hold -> 4 frames, each ss_n gap >= END_CYC+2 cycles.
REQ-036 hold=1 with FIFO non-empty -> ss_n stays all-ones and busy=1; hold raised mid-SHIFT -> frame completes unchanged.
REQ-037 rst asserted at the 5th SCLK edge -> outputs reach reset values with no clk edge, no rx_valid; after release busy=0 and cmd_ready=1.
REQ-038 RX_EN undefined, miso toggling -> rx_valid=0 and rx_data=0 throughout.
